// File: rtl/imem_loader.sv
// Serial byte stream to instruction memory loader. Assembles little-endian words,
// writes them one per word, and holds the core in stall until a load completes.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [15:0]           word_count,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);
  localparam logic [16:0]     DEPTH_L   = 17'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_W-1:0]     word_idx_q, word_idx_d;
  logic [BI_W-1:0]       byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  byte_ready_q;
  logic                  busy_q;
  logic                  core_hold_q;

  logic                  accept_s;
  logic                  too_big_s;
  logic                  last_word_s;

  assign accept_s    = byte_valid && byte_ready_q;
  assign too_big_s   = {1'b0, word_count} > DEPTH_L;
  // count_q is at least 1 whenever WRITE is reachable, so the subtraction cannot wrap.
  assign last_word_s = (16'(word_idx_q) == (count_q - 16'd1));

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          count_d    = word_count;
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
          asm_d      = '0;
          if (word_count == 16'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (too_big_s) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = RECV;
          end
        end else begin
          state_d = state_q;
        end
      end
      RECV: begin
        if (accept_s) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d  = '0;
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q;
            mem_wdata_d = asm_d;
          end else begin
            byte_idx_d = byte_idx_q + BI_W'(1);
          end
        end else begin
          state_d = RECV;
        end
      end
      WRITE: begin
        if (last_word_s) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = RECV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; status outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= 16'd0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      core_hold_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_ready_q <= (state_d == RECV);
      busy_q       <= (state_d == RECV) || (state_d == WRITE);
      core_hold_q  <= !((state_d == DONE) && done_d);
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_hold  = core_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a transaction-level model predicts every output
// each cycle, and a write monitor builds a shadow memory compared with the program image.
module tb_imem_loader;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [15:0]   word_count;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .word_count(word_count),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program bytes and reference model state
  logic [7:0]  prog [0:1023];
  bit          m_active = 1'b0;
  bit          m_wr     = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;
  int          m_word   = 0;
  int          m_count  = 0;
  logic [7:0]  m_bytes [$];
  logic [7:0]  m_addr   = '0;
  logic [31:0] m_data   = '0;

  // Model: one load = word_count words of 4 bytes each, each word followed by one write cycle.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_word = 0; m_count = 0; m_bytes.delete(); m_addr = '0; m_data = '0;
    end else if (!m_active) begin
      if (load_start) begin
        m_done = 1'b0; m_err = 1'b0;
        if (word_count == 16'd0) m_done = 1'b1;
        else if (int'(word_count) > DEPTH) m_err = 1'b1;
        else begin
          m_active = 1'b1; m_count = int'(word_count); m_word = 0; m_bytes.delete();
        end
      end
    end else if (m_wr) begin
      m_wr = 1'b0;
      if (m_word == m_count - 1) begin
        m_active = 1'b0; m_done = 1'b1;
      end else begin
        m_word++;
      end
    end else if (byte_valid) begin
      m_bytes.push_back(byte_data);
      if (m_bytes.size() == 4) begin
        m_wr   = 1'b1;
        m_addr = 8'(m_word);
        m_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_bytes.delete();
      end
    end
  end

  bit cmp_en = 1'b0;

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("byte_ready", byte_ready, m_active && !m_wr);
      chk("mem_we",     mem_we,     m_wr);
      chk("busy",       busy,       m_active);
      chk("core_hold",  core_hold,  !m_done);
      chk("done",       done,       m_done);
      chk("err",        err,        m_err);
      chk("mem_addr",   mem_addr,   m_addr);
      chk("mem_wdata",  mem_wdata,  m_data);
    end
  end

  // Write monitor: shadow memory plus a log of every write with its cycle number
  int          cyc_cnt  = 0;
  int          wr_total = 0;
  logic [31:0] shadow   [0:255];
  logic [7:0]  log_addr [0:2047];
  logic [31:0] log_data [0:2047];
  int          log_cyc  [0:2047];

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (mem_we === 1'b1 && wr_total < 2048) begin
      log_addr[wr_total] = mem_addr;
      log_data[wr_total] = mem_wdata;
      log_cyc[wr_total]  = cyc_cnt;
      shadow[mem_addr]   = mem_wdata;
      wr_total++;
    end
  end

  int done_cyc = 0;

  task automatic idle_noise(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'($urandom_range(0, 1));
      byte_data  = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic start_load(input int wc);
    @(negedge clk);
    load_start = 1'b1;
    word_count = 16'(wc);
    byte_valid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    word_count = 16'($urandom);
  endtask

  // Send nbytes of prog honouring byte_ready; gap_pct is the chance of an idle cycle.
  task automatic stream(input int nbytes, input int gap_pct, input bit noise_start);
    int  idx    = 0;
    int  cyc    = 0;
    int  budget = nbytes * 30 + 100;
    bit  v;
    while (idx < nbytes && cyc < budget) begin
      @(negedge clk);
      cyc++;
      v          = ($urandom_range(0, 99) >= gap_pct);
      byte_valid = v;
      byte_data  = v ? prog[idx] : 8'($urandom);
      load_start = noise_start && ($urandom_range(0, 19) == 0);
      word_count = 16'($urandom_range(0, 300));
      if (v && byte_ready === 1'b1) idx++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b0;
    if (idx < nbytes) chk("stream_timeout", idx, nbytes);
  endtask

  task automatic wait_end(input int budget);
    int c = 0;
    while (!(done === 1'b1 || err === 1'b1) && c < budget) begin
      @(negedge clk);
      c++;
    end
    done_cyc = cyc_cnt;
    if (c >= budget) chk("end_timeout", c, budget);
  endtask

  task automatic check_image(input int n, input int base);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (shadow[i] !== {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]}) bad++;
    chk("image_words_wrong", bad, 0);
    chk("write_count", wr_total - base, n);
  endtask

  task automatic rand_prog(input int nbytes);
    for (int i = 0; i < nbytes; i++) prog[i] = 8'($urandom);
  endtask

  initial begin
    logic [63:0] basic;
    int          base;
    int          n;
    rst = 1'b1; load_start = 1'b0; word_count = 16'd0; byte_data = 8'd0; byte_valid = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_core_hold", core_hold, 1'b1);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    idle_noise(6);
    chk("idle_no_load", busy, 1'b0);

    // Basic load, continuous stream
    basic = 64'h0010_0093_0000_0013;
    for (int i = 0; i < 8; i++) prog[i] = basic[8*i +: 8];
    base = wr_total;
    start_load(2);
    stream(8, 0, 1'b0);
    wait_end(50);
    chk("basic_nwr",   wr_total - base, 2);
    chk("basic_a0",    log_addr[base],     8'd0);
    chk("basic_d0",    log_data[base],     32'h0000_0013);
    chk("basic_a1",    log_addr[base + 1], 8'd1);
    chk("basic_d1",    log_data[base + 1], 32'h0010_0093);
    chk("basic_rate",  log_cyc[base + 1] - log_cyc[base], 5);
    chk("basic_done_lat", done_cyc - log_cyc[base + 1], 1);
    chk("basic_done",  done, 1'b1);
    chk("basic_hold",  core_hold, 1'b0);

    // Same program with random gaps and ignored load_start pulses
    base = wr_total;
    start_load(2);
    chk("reload_done_clr", done, 1'b0);
    chk("reload_hold",     core_hold, 1'b1);
    stream(8, 50, 1'b1);
    wait_end(200);
    chk("bp_nwr", wr_total - base, 2);
    chk("bp_d0",  log_data[base],     32'h0000_0013);
    chk("bp_d1",  log_data[base + 1], 32'h0010_0093);
    chk("bp_a1",  log_addr[base + 1], 8'd1);
    idle_noise(4);

    // Bounds: zero words and one past the depth
    base = wr_total;
    start_load(0);
    repeat (2) @(negedge clk);
    chk("wc0_done", done, 1'b1);
    chk("wc0_nwr",  wr_total - base, 0);
    start_load(257);
    repeat (2) @(negedge clk);
    chk("wc257_err",  err, 1'b1);
    chk("wc257_done", done, 1'b0);
    chk("wc257_hold", core_hold, 1'b1);
    chk("wc257_nwr",  wr_total - base, 0);

    // Randomized loads
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      rand_prog(4 * n);
      base = wr_total;
      start_load(n);
      stream(4 * n, 30, 1'b1);
      wait_end(100);
      check_image(n, base);
      idle_noise($urandom_range(0, 4));
    end

    // Full depth
    rand_prog(1024);
    base = wr_total;
    start_load(256);
    stream(1024, 10, 1'b1);
    wait_end(100);
    check_image(256, base);
    chk("full_last_addr", log_addr[wr_total - 1], 8'd255);
    chk("full_done", done, 1'b1);

    // Reset after 6 bytes of a 4-word load
    rand_prog(16);
    start_load(4);
    stream(6, 20, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_byte_ready", byte_ready, 1'b0);
    chk("mid_rst_mem_we",     mem_we,     1'b0);
    chk("mid_rst_busy",       busy,       1'b0);
    chk("mid_rst_done",       done,       1'b0);
    chk("mid_rst_err",        err,        1'b0);
    chk("mid_rst_core_hold",  core_hold,  1'b1);
    chk("mid_rst_mem_addr",   mem_addr,   8'd0);
    chk("mid_rst_mem_wdata",  mem_wdata,  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_noise(4);
    chk("post_rst_idle", busy, 1'b0);
    rand_prog(8);
    base = wr_total;
    start_load(2);
    stream(8, 20, 1'b0);
    wait_end(100);
    chk("post_rst_addr0", log_addr[base], 8'd0);
    check_image(2, base);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the instruction word width in bits (equal to INST_WIDTH).
REQ-002 SHALL have parameter DEPTH, default 256, giving the instruction memory depth in words.
REQ-003 SHALL have parameter ADDR_W, default 8, giving the word address width (clog2(DEPTH)).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 load_start  in  1  single-cycle request to begin a load.
REQ-007 word_count  in  16  number of words to load; sampled on an accepted load_start.
REQ-008 byte_data  in  8  serial program byte.
REQ-009 byte_valid  in  1  byte_data is valid.
REQ-010 byte_ready  out  1  loader accepts byte_data this cycle.
REQ-011 mem_we  out  1  instruction memory write enable.
REQ-012 mem_addr  out  ADDR_W  instruction memory word address.
REQ-013 mem_wdata  out  DATA_WIDTH  instruction word to write.
REQ-014 core_hold  out  1  holds the RV32I core stalled while it is high.
REQ-015 busy  out  1  load in progress.
REQ-016 done  out  1  last load completed successfully.
REQ-017 err  out  1  last load request was rejected.

Function
REQ-018 SHALL implement the FSM states IDLE, RECV, WRITE and DONE.
REQ-019 IDLE: on load_start, SHALL sample word_count and clear done and err, then go to:
- DONE with done=1 when word_count==0;
- DONE with err=1 and no writes when word_count>DEPTH;
- RECV otherwise, with the word index and byte index both cleared.
REQ-020 DONE SHALL behave like IDLE for load_start, so a reload is permitted.
REQ-021 load_start in RECV or WRITE SHALL be ignored.
REQ-022 byte_ready SHALL be 1 only in RECV; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-023 Bytes SHALL be assembled little-endian: 1st accepted byte -> bits 7:0, 2nd -> 15:8, 3rd -> 23:16, 4th -> 31:24.
REQ-024 byte_valid without byte_ready SHALL be ignored and SHALL NOT corrupt the assembly register.
REQ-025 Acceptance of the 4th byte SHALL move the FSM to WRITE.
REQ-026 In the cycle after the 4th byte is accepted, SHALL drive, for exactly one cycle:
- mem_we=1;
- mem_addr = word index;
- mem_wdata = assembled word.
REQ-027 mem_we SHALL be 0 in all states other than WRITE.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-029 WRITE SHALL go to DONE with done=1 when the word index equals word_count-1; otherwise it SHALL increment the word index and return to RECV.
REQ-030 The word index SHALL never exceed DEPTH-1, so there is no address wrap-around.
REQ-031 Minimum throughput SHALL be 5 cycles per word: 4 byte-accept cycles plus 1 write cycle.
REQ-032 busy SHALL be 1 in RECV and WRITE, and 0 in IDLE and DONE.
REQ-033 core_hold SHALL be 1 in IDLE, RECV and WRITE.
REQ-034 core_hold SHALL be 0 only in DONE with done=1; in DONE with err=1 it SHALL stay 1.
REQ-035 done and err SHALL be sticky until the next accepted load_start or reset, and SHALL never both be 1.

Reset
REQ-036 Asserting rst SHALL force IDLE immediately, asynchronously and at any point mid-load, with no further memory writes.
REQ-037 While rst is asserted and after its release:
- byte_ready=0, mem_we=0, busy=0, done=0, err=0;
- core_hold=1;
- mem_addr=0, mem_wdata=0;
- word index, byte index and assembly register = 0.
REQ-038 After rst is released, a load SHALL require a new load_start.

Verification
REQ-039 Basic load: load_start with word_count=2, bytes 13 00 00 00 93 00 10 00 streamed continuously -> writes 0x00000013 at addr 0, then 0x00100093 at addr 1; done=1 and core_hold=0 one cycle after the second write.
REQ-040 Backpressure and gaps: byte_valid toggled randomly -> identical writes to the basic load; no write before the 4th byte is accepted; bytes presented in IDLE or WRITE are not consumed.
REQ-041 Bounds:
- word_count=0 -> done=1, no writes;
- word_count=257 with DEPTH=256 -> err=1, core_hold=1, no writes;
- word_count=256 -> final write at addr 255.
REQ-042 Reset mid-load: rst asserted after 6 bytes of a 4-word load -> all outputs at reset values immediately; a subsequent load writes from addr 0.
REQ-043 Reload: load_start while in RECV is ignored; load_start in DONE clears done, raises core_hold and rewrites from addr 0.
